// File: rtl/mem_stage_ws.sv
// mem_stage_ws: MEM pipeline stage between EX and WB.
// Registers the EX payload and waits on variable-latency data SRAM reads
// through an rvalid handshake. Read data that arrives while the stage is held
// is kept in a local buffer. Loads are extracted and extended to 32 bits from
// the correct byte lane of a 32- or 64-bit bus. The stage flags misaligned
// loads and counts the cycles it spends stalled.
module mem_stage_ws #(
    parameter int DATA_W = 32,   // 32 or 64
    parameter int PC_W   = 32,
    parameter int HILO_W = 66,
    parameter int CNT_W  = 32
) (
    input  logic              clk,
    input  logic              rst,
    input  logic              stall_self,
    input  logic              stall_next,
    input  logic              ex_valid,
    input  logic [PC_W-1:0]   ex_pc,
    input  logic [31:0]       ex_result,
    input  logic [4:0]        ex_load_op,
    input  logic              ex_sel_rf_res,
    input  logic              ex_rf_we,
    input  logic [4:0]        ex_rf_waddr,
    input  logic [HILO_W-1:0] ex_hilo_bus,
    input  logic [DATA_W-1:0] dmem_rdata,
    input  logic              dmem_rvalid,
    output logic              stallreq,
    output logic              wb_valid,
    output logic [PC_W-1:0]   wb_pc,
    output logic              wb_rf_we,
    output logic [4:0]        wb_rf_waddr,
    output logic [31:0]       wb_rf_wdata,
    output logic [HILO_W-1:0] wb_hilo_bus,
    output logic              misalign,
    output logic [CNT_W-1:0]  wait_cnt
);

    localparam int NBYTES = DATA_W / 8;
    localparam int OFF_W  = $clog2(NBYTES);

    // Bit positions inside the one-hot {lb,lbu,lh,lhu,lw} load opcode.
    localparam int OP_LB  = 4;
    localparam int OP_LBU = 3;
    localparam int OP_LH  = 2;
    localparam int OP_LHU = 1;
    localparam int OP_LW  = 0;

    // IDLE: no data held locally; WAIT: load outstanding; HAVE: data buffered.
    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_WAIT = 2'd1,
        S_HAVE = 2'd2
    } state_t;

    // Stage register
    logic              r_valid;
    logic [PC_W-1:0]   r_pc;
    logic [31:0]       r_result;
    logic [4:0]        r_load_op;
    logic              r_sel_rf_res;
    logic              r_rf_we;
    logic [4:0]        r_rf_waddr;
    logic [HILO_W-1:0] r_hilo;

    state_t            r_state;
    state_t            w_nstate;
    logic              w_buf_ld;
    logic [DATA_W-1:0] r_buf;
    logic [CNT_W-1:0]  r_wait_cnt;

    logic              w_bubble;
    logic              w_capture;
    logic              w_upd;
    logic              w_is_ld;
    logic              w_mis;
    logic              w_ld;
    logic              w_stall;
    logic              w_wb_valid;
    logic [OFF_W-1:0]  w_off;
    logic [DATA_W-1:0] w_src;
    logic [31:0]       w_word;
    logic [7:0]        w_byte;
    logic [15:0]       w_half;
    logic [31:0]       w_ld_data;

    // The stall bus decides how the stage register moves. A bubble is loaded
    // when this stage is stalled but WB is free. A capture happens whenever
    // this stage is not stalled. Otherwise the register holds its value.
    assign w_bubble  = stall_self & ~stall_next;
    assign w_capture = ~stall_self;
    assign w_upd     = w_bubble | w_capture;

    // Stage register: capture the EX payload, load a bubble, or hold.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_result     <= '0;
            r_load_op    <= '0;
            r_sel_rf_res <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_hilo       <= '0;
        end else if (w_capture) begin
            r_valid      <= ex_valid;
            r_pc         <= ex_pc;
            r_result     <= ex_result;
            r_load_op    <= ex_load_op;
            r_sel_rf_res <= ex_sel_rf_res;
            r_rf_we      <= ex_rf_we;
            r_rf_waddr   <= ex_rf_waddr;
            r_hilo       <= ex_hilo_bus;
        end else if (w_bubble) begin
            r_valid      <= 1'b0;
            r_pc         <= '0;
            r_result     <= '0;
            r_load_op    <= '0;
            r_sel_rf_res <= 1'b0;
            r_rf_we      <= 1'b0;
            r_rf_waddr   <= '0;
            r_hilo       <= '0;
        end
    end

    // Misaligned loads never reach the SRAM handshake. They do not wait and
    // do not write back, so they are excluded from w_ld.
    assign w_is_ld = r_valid & r_sel_rf_res;
    assign w_mis   = w_is_ld &
                     ((((r_load_op[OP_LH] | r_load_op[OP_LHU]) & r_result[0])) |
                      (r_load_op[OP_LW] & (r_result[1:0] != 2'b00)));
    assign w_ld    = w_is_ld & ~w_mis;

    // A load stalls until its data is on the bus or already buffered.
    assign w_stall = w_ld & ~(dmem_rvalid | (r_state == S_HAVE));

    // FSM state register
    always_ff @(posedge clk or posedge rst) begin
        if (rst) r_state <= S_IDLE;
        else     r_state <= w_nstate;
    end

    // FSM next state. Any stage-register update drops back to IDLE, because
    // data present this cycle is consumed by WB on that same edge. Data that
    // arrives while the stage is held is latched into the buffer.
    always_comb begin
        w_nstate = r_state;
        w_buf_ld = 1'b0;
        if (w_upd) begin
            w_nstate = S_IDLE;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (w_ld) begin
                        if (dmem_rvalid) begin
                            w_buf_ld = 1'b1;
                            w_nstate = S_HAVE;
                        end else begin
                            w_nstate = S_WAIT;
                        end
                    end
                end
                S_WAIT: begin
                    if (dmem_rvalid) begin
                        w_buf_ld = 1'b1;
                        w_nstate = S_HAVE;
                    end
                end
                S_HAVE:  w_nstate = S_HAVE;
                default: w_nstate = S_IDLE;
            endcase
        end
    end

    // Read-data buffer for data returned while the stage is held.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)           r_buf <= '0;
        else if (w_buf_ld) r_buf <= dmem_rdata;
    end

    // Stall-cycle counter. It saturates at all-ones instead of wrapping.
    always_ff @(posedge clk or posedge rst) begin
        if (rst)
            r_wait_cnt <= '0;
        else if (w_stall && (r_wait_cnt != {CNT_W{1'b1}}))
            r_wait_cnt <= r_wait_cnt + CNT_W'(1);
    end

    // Shift the addressed lane down to bit 0. Only the low 32 bits are
    // needed, because no load is wider than a word.
    assign w_off  = r_result[OFF_W-1:0];
    assign w_src  = (r_state == S_HAVE) ? r_buf : dmem_rdata;
    assign w_word = 32'(w_src >> {w_off, 3'b000});
    assign w_byte = w_word[7:0];
    assign w_half = w_word[15:0];

    // Load extraction with sign or zero extension.
    always_comb begin
        w_ld_data = '0;
        if (r_load_op[OP_LB])       w_ld_data = {{24{w_byte[7]}}, w_byte};
        else if (r_load_op[OP_LBU]) w_ld_data = {24'd0, w_byte};
        else if (r_load_op[OP_LH])  w_ld_data = {{16{w_half[15]}}, w_half};
        else if (r_load_op[OP_LHU]) w_ld_data = {16'd0, w_half};
        else if (r_load_op[OP_LW])  w_ld_data = w_word;
    end

    assign w_wb_valid  = r_valid & ~w_stall;

    assign stallreq    = w_stall;
    assign wb_valid    = w_wb_valid;
    assign wb_pc       = r_pc;
    assign wb_rf_we    = r_rf_we & w_wb_valid & ~w_mis;
    assign wb_rf_waddr = r_rf_waddr;
    assign wb_rf_wdata = w_mis ? 32'd0 : (r_sel_rf_res ? w_ld_data : r_result);
    assign wb_hilo_bus = r_hilo;
    assign misalign    = w_mis;
    assign wait_cnt    = r_wait_cnt;

endmodule

// File: doc/mem_stage_ws.md
Name: mem_stage_ws

Overview:
- Parametrised successor of the current MEM pipeline stage, sitting between EX and WB of the SampleCPU pipeline.
- Registers the EX→MEM payload and supports variable-latency data SRAM reads through an rvalid handshake, requesting a pipeline stall while a load waits.
- Buffers read data that arrives while the stage is held.
- Performs full load extraction (lb/lbu/lh/lhu/lw), byte-lane aware for 32- or 64-bit data buses.
- Flags misaligned loads and counts load wait cycles.

Parameters:
- DATA_W, 32, data bus width; legal values 32 or 64. Loads are always ≤32 bits and are zero/sign-extended to 32.
- PC_W, 32, PC width.
- HILO_W, 66, width of the hi/lo pass-through bus.
- CNT_W, 32, width of the wait-cycle counter.

Ports:
- clk  in  1  clock
- rst  in  1  asynchronous active-high reset
- stall_self  in  1  stall-bus bit for this stage (`Stop = 1)
- stall_next  in  1  stall-bus bit for WB
- ex_valid  in  1  EX payload valid
- ex_pc  in  PC_W  instruction PC
- ex_result  in  32  ALU result; this is the load address when ex_sel_rf_res=1
- ex_load_op  in  5  one-hot {lb,lbu,lh,lhu,lw}
- ex_sel_rf_res  in  1  1 = instruction is a load
- ex_rf_we  in  1  register-file write enable
- ex_rf_waddr  in  5  destination register
- ex_hilo_bus  in  HILO_W  hi/lo write info, passed through
- dmem_rdata  in  DATA_W  SRAM read data
- dmem_rvalid  in  1  dmem_rdata valid this cycle for the load in MEM
- stallreq  out  1  MEM requests a pipeline stall
- wb_valid  out  1  payload valid to WB
- wb_pc  out  PC_W
- wb_rf_we  out  1
- wb_rf_waddr  out  5
- wb_rf_wdata  out  32
- wb_hilo_bus  out  HILO_W
- misalign  out  1  current load is misaligned
- wait_cnt  out  CNT_W  total cycles stallreq has been asserted

Behaviour:
- Reset (asynchronous): stage register, FSM, buffer and wait_cnt clear. All outputs are 0 while rst is high.
- Stage register update, by priority:
  - stall_self=1 and stall_next=0 → load a bubble (all fields 0).
  - stall_self=0 → capture ex_*.
  - Otherwise → hold.
- FSM states: IDLE, WAIT, HAVE. Any stage-register update (capture or bubble) forces IDLE.
  - IDLE: if the register holds a valid load and dmem_rvalid=0 → go to WAIT.
  - IDLE: if the load sees dmem_rvalid=1 while stall_self=1 → latch dmem_rdata into the buffer and go to HAVE.
  - WAIT: on dmem_rvalid, if still held → latch the buffer and go to HAVE; if not held → the stage register updates, so go to IDLE.
  - HAVE: hold until the stage register updates.
- dmem_rvalid while the MEM register is not a valid load is ignored.
- Load data source: the buffer in HAVE, otherwise dmem_rdata.
- stallreq = valid & load & !(dmem_rvalid | state==HAVE); combinational. A zero-wait load causes no stall.
- wait_cnt increments every cycle stallreq=1 and saturates at all-ones.
- Extraction:
  - off = ex_result[log2(DATA_W/8)-1:0].
  - lb/lbu: byte at lane off, sign- or zero-extended.
  - lh/lhu: halfword at lane off, sign- or zero-extended.
  - lw: word at lane off.
- Misalignment:
  - misalign=1 for lh/lhu with off[0]=1, and for lw with off[1:0]≠0.
  - A misaligned load forces wb_rf_we=0 and wb_rf_wdata=0, and does not raise stallreq.
- WB outputs are combinational from the stage register and the extracted data:
  - wb_rf_wdata = extracted load data if sel_rf_res, else result.
  - wb_valid = valid & !stallreq.
  - wb_rf_we = rf_we & wb_valid & !misalign.
- Non-load instructions pass through with zero added latency.
- A reset asserted during WAIT or HAVE discards the pending load. An rvalid arriving after reset release is ignored.

Test Plan:
- lw at 0x100, rvalid in the same cycle with rdata=0xDEADBEEF (DATA_W=32) → no stallreq; wb_rf_wdata=0xDEADBEEF, wb_rf_we=1.
- lb at 0x103, rdata=0x80xxxxxx → wb_rf_wdata=0xFFFFFF80. The same access with lbu → 0x00000080.
- lh at 0x101 → misalign=1, wb_rf_we=0, stallreq=0.
- lw, rvalid after 3 cycles → stallreq high for exactly 3 cycles, wait_cnt=3, then a single WB write of the correct data.
- lw with stall_self=stall_next=1 held for 2 cycles, rvalid in the first → data buffered; after release, WB receives the buffered value even though dmem_rdata has changed.
- DATA_W=64, lhu at offset 6, rdata=0xABCD_0000_0000_0000 → 0x0000ABCD.
- Reset pulse mid-WAIT → all outputs 0; a later stray rvalid causes no write.
